// File: rtl/ins_assembler.sv
// rtl/ins_assembler.sv - OCM instruction byte assembler with length check and decoder queue
// Optional feature macro: INS_PREFETCH_EN (queue depth 2, fetch ahead while head awaits InsAck)
module ins_assembler (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       FetchEn,
  input  logic       Flush,
  input  logic       OcmReady,
  input  logic       GiveIns,
  input  logic [1:0] SIns,
  input  logic [7:0] InsByte,
  output logic       OcmStart,
  output logic       InsValid,
  output logic [7:0] Opcode,
  output logic [7:0] Operand1,
  output logic [7:0] Operand2,
  output logic [1:0] InsLen,
  input  logic       InsAck,
  output logic       Err
);

`ifdef INS_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [1:0] DEPTH_C = 2'(DEPTH);
  localparam int EW = 26;  // {opcode, operand1, operand2, len}

  typedef enum logic [1:0] {F_IDLE, F_START, F_WAIT, F_COLLECT} state_t;

  state_t                    state_q, state_d;
  logic                      wait_cnt_q, wait_cnt_d;
  logic [2:0][7:0]           byte_q, byte_d;
  logic [2:0]                seen_q, seen_d;
  logic                      drop_q, drop_d;
  logic                      err_q, err_d;
  logic [DEPTH-1:0][EW-1:0]  mem_q, mem_d;
  logic [1:0]                cnt_q, cnt_d;
  logic                      push;
  logic [EW-1:0]             push_entry;
  logic                      pop;
  logic                      full;
  logic [1:0]                wr_idx;
  logic [1:0]                op_len;

  // Instruction length by opcode; 0 marks an illegal opcode
  function automatic logic [1:0] len_of(input logic [7:0] op);
    if (op == 8'h16 || (op >= 8'h41 && op <= 8'h46)) return 2'd2;
    else if (op == 8'h4A) return 2'd3;
    else if (op <= 8'h19 || (op >= 8'h40 && op <= 8'h4C) || op == 8'h80 || op == 8'h81) return 2'd1;
    else return 2'd0;
  endfunction

  // Seen-bit pattern a well-formed transfer of the given length produces
  function automatic logic [2:0] seen_mask(input logic [1:0] len);
    case (len)
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      2'd3:    return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  assign pop      = (cnt_q != 2'd0) && InsAck;
  assign full     = (cnt_q == DEPTH_C);
  assign wr_idx   = pop ? (cnt_q - 2'd1) : cnt_q;
  assign op_len   = len_of(byte_q[0]);

  assign OcmStart = (state_q == F_START);
  assign InsValid = (cnt_q != 2'd0);
  assign Opcode   = mem_q[0][25:18];
  assign Operand1 = mem_q[0][17:10];
  assign Operand2 = mem_q[0][9:2];
  assign InsLen   = mem_q[0][1:0];
  assign Err      = err_q;

  // Fetch FSM: start OCM, collect strobed bytes, validate and commit on OcmReady
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    byte_d     = byte_q;
    seen_d     = seen_q;
    drop_d     = drop_q;
    err_d      = err_q;
    push       = 1'b0;
    push_entry = '0;
    // A flush during a transaction lets OCM finish but forbids the commit
    if (Flush && state_q != F_IDLE) drop_d = 1'b1;
    unique case (state_q)
      F_IDLE: begin
        if (FetchEn && OcmReady && !Flush && (!full || pop)) state_d = F_START;
      end
      F_START: begin
        state_d    = F_WAIT;
        wait_cnt_d = 1'b0;
        byte_d     = '0;
        seen_d     = '0;
      end
      F_WAIT: begin
        if (!OcmReady) begin
          state_d = F_COLLECT;
        end else if (wait_cnt_q) begin
          err_d   = 1'b1;
          drop_d  = 1'b0;
          state_d = F_IDLE;
        end else begin
          wait_cnt_d = 1'b1;
        end
      end
      F_COLLECT: begin
        if (OcmReady) begin
          state_d = F_IDLE;
          drop_d  = 1'b0;
          if (seen_q == 3'b000) begin
            push = !Flush && !drop_q;
          end else if (seen_q == seen_mask(op_len)) begin
            push       = !Flush && !drop_q;
            push_entry = {byte_q[0], byte_q[1], byte_q[2], op_len};
          end else begin
            err_d = 1'b1;
          end
        end else if (GiveIns) begin
          if (SIns == 2'd3) begin
            err_d = 1'b1;
          end else begin
            byte_d[SIns] = InsByte;
            seen_d[SIns] = 1'b1;
          end
        end
      end
      default: state_d = F_IDLE;
    endcase
  end

  // FSM and capture registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= F_IDLE;
      wait_cnt_q <= 1'b0;
      byte_q     <= '0;
      seen_q     <= '0;
      drop_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      byte_q     <= byte_d;
      seen_q     <= seen_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
    end
  end

  // Shift-register queue: head in slot 0, flush beats push and pop
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (Flush) begin
      mem_d = '0;
      cnt_d = 2'd0;
    end else begin
      if (pop) mem_d = mem_q >> EW;
      if (push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (2'(i) == wr_idx) mem_d[i] = push_entry;
        end
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Queue storage and occupancy
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mem_q <= '0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: doc/ins_assembler.md
# ins_assembler

Downstream consumer of the on-chip-memory instruction controller. Starts OCM fetch transactions with a one-cycle Start pulse, captures the byte stream that OCM presents with GiveIns/SIns, and checks the byte count against the opcode's length. It then queues complete, length-tagged instructions for the CPU decoder behind a valid/ack handshake.

## Interface
- No parameters; queue depth fixed by `INS_PREFETCH_EN` (see Configuration).
- Clk  in  1  system clock, all state on rising edge
- Rst  in  1  reset, asynchronous, active-high
- FetchEn  in  1  permit new OCM fetches
- Flush  in  1  one-cycle pulse: discard queue and any in-flight instruction
- OcmReady  in  1  OCM Ready (high only in OCM Idle)
- GiveIns  in  1  OCM byte strobe
- SIns  in  2  byte index of strobed byte: 0 opcode, 1 operand1, 2 operand2
- InsByte  in  8  byte data, valid when GiveIns=1
- OcmStart  out  1  Start to OCM
- InsValid  out  1  queue head holds an instruction
- Opcode, Operand1, Operand2  out  8 each  queue-head bytes (unused operands read 0)
- InsLen  out  2  queue-head length 1..3; 0 = illegal opcode
- InsAck  in  1  decoder pops head; ignored when InsValid=0
- Err  out  1  sticky protocol error; cleared only by Rst

## Operation
- Length table:
  - 2: 0x16, 0x41–0x46
  - 3: 0x4A
  - 1: rest of 0x00–0x19, 0x40–0x4C, 0x80–0x81
  - all other opcodes illegal; OCM sends no bytes for them.
- FSM states:
  - F_IDLE: go to F_START when FetchEn & OcmReady & queue not full & !Flush.
  - F_START: OcmStart=1 for exactly this one cycle; always → F_WAIT.
  - F_WAIT: → F_COLLECT when OcmReady=0. If OcmReady is still 1 after 2 cycles in F_WAIT, set Err and → F_IDLE.
  - F_COLLECT: on each GiveIns, store InsByte into slot SIns and set that slot's seen bit. When OcmReady=1, commit and → F_IDLE.
- Commit rules:
  - No bytes seen: push entry with InsLen=0, Opcode=0.
  - Bytes seen: push with InsLen = table length of the captured opcode.
  - Seen-bit pattern differs from the table length: set Err, push nothing.
- Discard rules:
  - GiveIns with SIns=3: set Err, discard the byte.
  - A repeated index overwrites the earlier byte.
- Queue: FIFO with write on commit and read on InsValid&InsAck.
  - Simultaneous push and pop on a full queue is legal; count is unchanged.
- Flush: empties the queue the same cycle and sets a drop flag.
  - The in-flight transaction, if any, still runs to OcmReady=1 but is not pushed.
  - The FSM never aborts OCM mid-transaction, because OCM has no abort input.
- Reset values: OcmStart=0, InsValid=0, Opcode/Operand1/Operand2=0, InsLen=0, Err=0, FSM=F_IDLE, queue empty, drop flag clear.
- Rst mid-transaction returns to F_IDLE. Any OCM transaction still running completes unobserved; the next start waits for OcmReady=1.

## Timing
- Start pulse at cycle t; OCM OcmReady=0 at t+1.
- GiveIns strobes for SIns 0/1/2 at t+3, t+4, t+5, as applicable.
- OcmReady=1 at t+6; the commit edge is at the end of t+6. InsValid=1 at t+7 when the queue was empty.
- Per-instruction fetch period is 8 cycles, including the F_IDLE decision cycle.
- Head outputs are registered; they change only on pop, or on a push into an empty queue.
- InsAck at cycle c: the next head (or InsValid=0) is visible at c+1.
- Flush and a commit in the same cycle: the flush wins and the entry is dropped.

## Configuration
- `INS_PREFETCH_EN` defined:
  - Queue depth 2.
  - Fetch of the next instruction may start while the head waits for InsAck.
- Undefined:
  - Queue depth 1.
  - F_IDLE leaves only when the queue is empty, or when InsAck pops the single entry that same cycle.
- Handshake, timing and Err rules are identical in both builds.

## Test plan
- Fetch 0x05 (len 1), GiveIns only at SIns=0:
  - OcmStart at t, InsValid at t+7, Opcode=0x05, InsLen=1, Operand1=Operand2=0.
- Fetch 0x4A, 0x11, 0x22:
  - Entry 0x4A/0x11/0x22, InsLen=3.
  - Then 0x16, 0x33: entry InsLen=2, Operand2=0.
- Opcode 0x90 (OCM gives no bytes):
  - Entry with InsLen=0, Err stays 0.
  - Then 0x16 with only SIns=0 strobed: Err=1, no entry pushed.
- Prefetch build, InsAck held 0:
  - Exactly two entries queued, no third OcmStart.
  - Single InsAck: next OcmStart in the cycle after the pop.
- Flush at t+4 of a 0x41 fetch:
  - Queue empty at t+5, nothing pushed at t+6.
  - Next fetch starts from F_IDLE after OcmReady=1.
- Rst asserted at t+3:
  - All outputs are their reset values immediately.
  - OcmStart stays 0 until OcmReady is seen high with FetchEn=1.
